// File: rtl/ad7476a_sample_scheduler_pkg.sv
// Shared definitions for the AD7476A sample scheduler: sample width, FSM
// state encoding and the sample-period helper.
package ad7476a_sample_scheduler_pkg;

  localparam int unsigned SAMPLE_WIDTH = 12;
  localparam int unsigned MAX_AVG_LOG2 = 8;

  // Conversion sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUEST   = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_ACCUM     = 2'd3
  } state_e;

  // Clocks per conversion request; 0 flags an unusable rate
  function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                input int unsigned rate_hz);
    if (rate_hz == 0) begin
      return 0;
    end
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/ad7476a_sample_scheduler_channel_averager.sv
// Per-channel accumulator for the sample scheduler.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : clear accumulator (wins over add_i)
//   add_i         : add sample_i into the accumulator
//   sample_i      : 12-bit unsigned conversion result
//   result_o      : truncated average, acc[AVG_LOG2 +: 12] of the registered sum
module ad7476a_sample_scheduler_channel_averager
  import ad7476a_sample_scheduler_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    add_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  output logic [SAMPLE_WIDTH-1:0] result_o
);

  // Wide enough for 2^AVG_LOG2 full-scale samples, so no saturation needed
  localparam int unsigned ACC_W = SAMPLE_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Next accumulator value
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(sample_i);
    end
  end

  // Accumulator register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign result_o = acc_q[AVG_LOG2 +: SAMPLE_WIDTH];

endmodule

// File: rtl/ad7476a_sample_scheduler.sv
// Fixed-rate conversion scheduler for the AD7476A SPI front end. Issues a
// periodic one-cycle request, collects 2^AVG_LOG2 samples per channel and
// presents the truncated average on a valid/ready stream. Missed request
// slots, dropped results and hung conversions raise sticky flags.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   enable_i          : run the period counter
//   clear_flags_i     : clear overrun_o and timeout_o
//   adc_request_o     : one-cycle conversion request
//   adc_data_i        : samples, channel i at [12*i +: 12]
//   adc_data_valid_i  : one-cycle sample strobe
//   m_data_o          : averaged samples, channel i at [12*i +: 12]
//   m_valid_o         : output word valid
//   m_ready_i         : downstream accept
//   busy_o            : conversion in flight
//   overrun_o         : sticky, tick missed or result dropped
//   timeout_o         : sticky, conversion timed out
module ad7476a_sample_scheduler
  import ad7476a_sample_scheduler_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned SAMPLE_RATE_HZ = 1000000,
  parameter int unsigned NUM_DEVICES    = 1,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                clear_flags_i,
  output logic                                adc_request_o,
  input  logic [SAMPLE_WIDTH*NUM_DEVICES-1:0] adc_data_i,
  input  logic                                adc_data_valid_i,
  output logic [SAMPLE_WIDTH*NUM_DEVICES-1:0] m_data_o,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic                                busy_o,
  output logic                                overrun_o,
  output logic                                timeout_o
);

  localparam int unsigned PERIOD = period_cycles(CLK_FREQ_HZ, SAMPLE_RATE_HZ);
  localparam int unsigned PER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AVG_N  = 1 << AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned DATA_W = SAMPLE_WIDTH * NUM_DEVICES;

  // Reject configurations the datapath cannot honour
  if (PERIOD < 2 || AVG_LOG2 > MAX_AVG_LOG2 || TIMEOUT_CYCLES < 1 ||
      NUM_DEVICES < 1) begin : g_bad_cfg
    $error("ad7476a_sample_scheduler: unsupported parameter set");
  end

  state_e              state_q, state_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic                last_q, last_d;
  logic                enable_q;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic                tick_c;
  logic                en_rise_c;
  logic                strobe_acc_c;
  logic                tmo_evt_c;
  logic                load_c;
  logic                drop_tick_c;
  logic                drop_result_c;
  logic                avg_clr_c;
  logic [DATA_W-1:0]   avg_result;

  assign tick_c    = enable_i && (per_cnt_q == PER_W'(PERIOD - 1));
  assign en_rise_c = enable_i && !enable_q;

  // Sequencer next state and registered request/busy
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    strobe_acc_c = 1'b0;
    tmo_evt_c    = 1'b0;
    req_d        = 1'b0;
    busy_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_c) begin
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        state_d = ST_WAIT_DATA;
        tmo_d   = '0;
      end
      ST_WAIT_DATA: begin
        // A strobe on the last allowed cycle still counts as on time
        if (adc_data_valid_i) begin
          strobe_acc_c = 1'b1;
          state_d      = ST_ACCUM;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_evt_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_ACCUM: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d  = (state_d == ST_REQUEST);
    busy_d = (state_d != ST_IDLE);
  end

  // The averaged word is ready in the ACCUM cycle following the final strobe
  assign load_c        = (state_q == ST_ACCUM) && last_q;
  assign drop_tick_c   = tick_c && (state_q != ST_IDLE);
  assign drop_result_c = load_c && m_valid_q && !m_ready_i;
  assign avg_clr_c     = en_rise_c || load_c;

  // Period counter, sample count, output register and flags
  always_comb begin
    per_cnt_d = '0;
    smp_cnt_d = smp_cnt_q;
    last_d    = last_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    if (enable_i && !tick_c) begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end

    // Re-enable discards any partial average, including a same-cycle strobe
    if (en_rise_c || load_c) begin
      smp_cnt_d = '0;
      last_d    = 1'b0;
    end else if (strobe_acc_c) begin
      smp_cnt_d = smp_cnt_q + CNT_W'(1);
      last_d    = (smp_cnt_q == CNT_W'(AVG_N - 1));
    end

    if (load_c && !drop_result_c) begin
      m_data_d  = avg_result;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    // Set events beat a simultaneous clear
    if (drop_tick_c || drop_result_c) begin
      overrun_d = 1'b1;
    end else if (clear_flags_i) begin
      overrun_d = 1'b0;
    end

    if (tmo_evt_c) begin
      timeout_d = 1'b1;
    end else if (clear_flags_i) begin
      timeout_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      tmo_q     <= '0;
      smp_cnt_q <= '0;
      last_q    <= 1'b0;
      enable_q  <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_q     <= tmo_d;
      smp_cnt_q <= smp_cnt_d;
      last_q    <= last_d;
      enable_q  <= enable_i;
      req_q     <= req_d;
      busy_q    <= busy_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // One accumulator per ADC channel
  for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_chan
    ad7476a_sample_scheduler_channel_averager #(
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (avg_clr_c),
      .add_i    (strobe_acc_c),
      .sample_i (adc_data_i[SAMPLE_WIDTH*g +: SAMPLE_WIDTH]),
      .result_o (avg_result[SAMPLE_WIDTH*g +: SAMPLE_WIDTH])
    );
  end

  assign adc_request_o = req_q;
  assign busy_o        = busy_q;
  assign m_data_o      = m_data_q;
  assign m_valid_o     = m_valid_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ad7476a_sample_scheduler.sv
// Randomized bench for ad7476a_sample_scheduler. The bench plays the ADC
// interface and keeps a timestamp-based reference of the conversion schedule,
// the per-channel averages and the output stream, checked every cycle.
`timescale 1ns/1ps
module tb_ad7476a_sample_scheduler;

  localparam int unsigned PERIOD = 100;
  localparam int unsigned NDEV   = 2;
  localparam int unsigned AVG    = 2;
  localparam int unsigned NAVG   = 4;
  localparam int unsigned TMO    = 256;
  localparam int unsigned DW     = 12 * NDEV;

  logic          clk = 1'b0;
  logic          rst_n, enable, clear_flags, adc_valid, m_ready;
  logic [DW-1:0] adc_data;
  logic          adc_req, m_valid, busy, overrun, timeout;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  ad7476a_sample_scheduler #(
    .CLK_FREQ_HZ    (100000000),
    .SAMPLE_RATE_HZ (1000000),
    .NUM_DEVICES    (NDEV),
    .AVG_LOG2       (AVG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .clear_flags_i    (clear_flags),
    .adc_request_o    (adc_req),
    .adc_data_i       (adc_data),
    .adc_data_valid_i (adc_valid),
    .m_data_o         (m_data),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready),
    .busy_o           (busy),
    .overrun_o        (overrun),
    .timeout_o        (timeout)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  // Stimulus knobs
  bit k_en, k_never, k_fixed;
  int k_ready_pct, k_clr_pct, k_dmin, k_dmax, fixed_idx;

  // ADC model: one pending strobe
  bit     a_pend;
  longint a_at;

  // Reference model
  int      m_phase;
  bit      m_en_prev;
  bit      conv_on, conv_done;
  longint  conv_r, idle_from;
  int      sum [NDEV];
  int      n_acc;
  bit      load_pend;
  longint  load_at;
  logic [DW-1:0] res_word;
  bit      e_ov, e_ovr, e_tmo, e_req, e_busy;
  logic [DW-1:0] e_od;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_phase = 0; m_en_prev = 0; conv_on = 0; conv_done = 0;
    conv_r = 0; idle_from = 0; n_acc = 0; load_pend = 0; load_at = 0;
    foreach (sum[i]) sum[i] = 0;
    res_word = '0;
    e_ov = 0; e_od = '0; e_ovr = 0; e_tmo = 0; e_req = 0; e_busy = 0;
  endtask

  // Advance the reference by one cycle of inputs; predictions are for the next cycle
  task automatic model(input bit rstn_in, input bit en, input bit rdy, input bit clr,
                       input bit stb, input logic [DW-1:0] d);
    bit tick, busy_now, rise, ovr_set, tmo_set, acc_stb;
    if (!rstn_in) begin
      model_reset();
      return;
    end
    tick    = en && (m_phase == PERIOD - 1);
    m_phase = (en && !tick) ? m_phase + 1 : 0;
    rise    = en && !m_en_prev;
    m_en_prev = en;
    busy_now = conv_on && cyc >= conv_r && cyc < idle_from;
    ovr_set = 0; tmo_set = 0; e_req = 0;

    acc_stb = stb && conv_on && !conv_done && cyc > conv_r && cyc <= conv_r + TMO;
    if (acc_stb) begin
      conv_done = 1;
      idle_from = cyc + 2;
    end else if (conv_on && !conv_done && cyc == conv_r + TMO) begin
      conv_done = 1;
      tmo_set   = 1;
    end

    if (rise) begin
      foreach (sum[i]) sum[i] = 0;
      n_acc = 0;
    end else if (acc_stb) begin
      for (int ch = 0; ch < NDEV; ch++) sum[ch] += int'(d[12*ch +: 12]);
      n_acc++;
      if (n_acc == NAVG) begin
        for (int ch = 0; ch < NDEV; ch++) res_word[12*ch +: 12] = 12'(sum[ch] / NAVG);
        load_pend = 1;
        load_at   = cyc + 1;
        foreach (sum[i]) sum[i] = 0;
        n_acc = 0;
      end
    end

    if (load_pend && load_at == cyc) begin
      load_pend = 0;
      if (e_ov && !rdy) ovr_set = 1;
      else begin
        e_od = res_word;
        e_ov = 1;
      end
    end else if (e_ov && rdy) begin
      e_ov = 0;
    end

    if (tick) begin
      if (busy_now) ovr_set = 1;
      else begin
        conv_on = 1; conv_done = 0;
        conv_r = cyc + 1;
        idle_from = cyc + 2 + TMO;
        e_req = 1;
        if (!k_never) begin
          a_pend = 1;
          a_at   = conv_r + longint'($urandom_range(k_dmax, k_dmin));
        end
      end
    end

    e_busy = conv_on && (cyc + 1) >= conv_r && (cyc + 1) < idle_from;
    e_ovr  = ovr_set ? 1'b1 : (clr ? 1'b0 : e_ovr);
    e_tmo  = tmo_set ? 1'b1 : (clr ? 1'b0 : e_tmo);
  endtask

  // One clock: check predictions, then drive and model this cycle's inputs
  task automatic step(input bit rstn_in);
    logic [DW-1:0] d;
    bit rdy, clr, stb;
    @(posedge clk);
    cyc++;
    #1;
    chk("adc_request", adc_req, e_req);
    chk("busy", busy, e_busy);
    chk("m_valid", m_valid, e_ov);
    chk("m_data", m_data, e_od);
    chk("overrun", overrun, e_ovr);
    chk("timeout", timeout, e_tmo);
    rdy = ($urandom_range(99) < k_ready_pct);
    clr = ($urandom_range(99) < k_clr_pct);
    stb = a_pend && (a_at == cyc);
    if (stb) a_pend = 0;
    d = DW'($urandom);
    if (stb && k_fixed) begin
      d[11:0] = 12'((fixed_idx % 4) + 1);
      fixed_idx++;
    end
    rst_n = rstn_in; enable = k_en; m_ready = rdy;
    clear_flags = clr; adc_valid = stb; adc_data = d;
    model(rstn_in, k_en, rdy, clr, stb, d);
  endtask

  initial begin
    rst_n = 0; enable = 0; clear_flags = 0; adc_valid = 0; adc_data = '0; m_ready = 0;
    model_reset();
    a_pend = 0; a_at = 0; fixed_idx = 0;
    k_en = 0; k_never = 0; k_fixed = 1; k_ready_pct = 100; k_clr_pct = 0;
    k_dmin = 10; k_dmax = 10;
    repeat (3) step(0);

    // Samples 1,2,3,4 on channel 0 average to 2
    k_en = 1;
    repeat (900) step(1);
    chk("avg_ch0_word", 32'(m_data[11:0]), 32'h002);

    // Random data, reply delays and back-pressure
    k_fixed = 0; k_dmin = 1; k_dmax = 90; k_ready_pct = 60; k_clr_pct = 2;
    repeat (4000) step(1);

    // Stalled consumer: results dropped, then flags cleared
    k_ready_pct = 0; k_clr_pct = 0; k_dmin = 10; k_dmax = 10;
    repeat (1000) step(1);
    chk("overrun_after_stall", overrun, 1'b1);
    k_ready_pct = 100; k_clr_pct = 100;
    step(1);
    k_clr_pct = 0;
    repeat (5) step(1);

    // Hung ADC, then replies around the timeout boundary
    k_never = 1;
    repeat (1200) step(1);
    k_never = 0; k_dmin = TMO - 1; k_dmax = TMO + 1; k_clr_pct = 1;
    repeat (3000) step(1);

    // Slow replies overlap the next tick
    k_dmin = 150; k_dmax = 150;
    repeat (1000) step(1);

    // Enable toggling with in-flight conversions
    k_dmin = 1; k_dmax = 120; k_ready_pct = 80;
    for (int i = 0; i < 60; i++) begin
      k_en = 1'($urandom_range(1));
      repeat ($urandom_range(80, 5)) step(1);
    end

    // Reset during WAIT_DATA with a stale strobe after release
    k_en = 1; k_clr_pct = 0; k_ready_pct = 100;
    for (int rep = 0; rep < 3; rep++) begin
      bit reached;
      reached = 0;
      k_never = 1;
      for (int i = 0; i < 400 && !reached; i++) begin
        step(1);
        if (conv_on && !conv_done && cyc > conv_r + 5) reached = 1;
      end
      chk("busy_before_reset", busy, 1'b1);
      step(0);
      step(0);
      a_pend = 1;
      a_at   = cyc + 4;
      k_never = 0; k_dmin = 10; k_dmax = 40;
      repeat (60) step(1);
      chk("post_reset_valid", m_valid, 1'b0);
      chk("post_reset_data", m_data, '0);
      repeat (900) step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
